// File: rtl/pi_pkg.sv
// Shared constants and FSM encoding for the fixed-point series engines.
package pi_pkg;

    localparam int FRAC    = 16;
    localparam int ONE_Q   = 65536;
    localparam int DIV_CYC = 32;
    localparam int DIV_CW  = $clog2(DIV_CYC);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DIV   = 3'd2,
        ST_ACC   = 3'd3,
        ST_SCALE = 3'd4,
        ST_DONE  = 3'd5
    } pi_state_e;

endpackage

// File: rtl/pi_udiv.sv
// Unsigned restoring divider: one quotient bit per clock, quotient and a
// one-cycle rdy pulse W clocks after the edge that samples go.
module pi_udiv #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quot,
    output logic         rdy
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic          rdy_q;

    logic [W:0]    rem_sh;
    logic          fits;
    logic [W-1:0]  rem_d;

    // The dividend shifts out of quo_q's MSB while quotient bits shift into its LSB.
    always_comb begin
        rem_sh = {rem_q, quo_q[W-1]};
        fits   = (rem_sh >= {1'b0, dvs_q});
        rem_d  = fits ? (rem_sh[W-1:0] - dvs_q) : rem_sh[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (go) begin
                rem_q <= '0;
                quo_q <= dividend;
                dvs_q <= divisor;
                cnt_q <= '0;
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= rem_d;
                quo_q <= {quo_q[W-2:0], fits};
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    run_q <= 1'b0;
                    rdy_q <= 1'b1;
                end
            end
        end
    end

    assign quot = quo_q;
    assign rdy  = rdy_q;

endmodule

// File: rtl/pi_series_engine.sv
// Run-time Leibniz series for pi in Q16.16: one shared divide per term,
// alternating-sign accumulation, final scale by four.
module pi_series_engine #(
    parameter int W    = 32,
    parameter int FRAC = pi_pkg::FRAC,
    parameter int N_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_W-1:0]    n_terms,
    output logic              busy,
    output logic              done,
    output logic [W-1:0]      pi_out,
    output pi_pkg::pi_state_e state_dbg
);

    import pi_pkg::*;

    // Handshake: start is taken only in IDLE while done is low, n_terms is
    // captured on that edge, busy rises the next cycle, and done pulses for one
    // cycle as busy falls; pi_out is valid from the done pulse until the next run's SCALE.
    localparam int            KW  = N_W + 2;
    localparam logic [W-1:0]  ONE = W'(1) << FRAC;

    pi_state_e         state_q;
    logic [N_W-1:0]    n_q;
    logic [KW-1:0]     k_q;
    logic [KW-1:0]     d_q;
    logic [W-1:0]      acc_q;
    logic [W-1:0]      acc_d;
    logic [W-1:0]      pi_q;
    logic [DIV_CW-1:0] cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              go_q;

    logic [W-1:0]      divisor;
    logic [W-1:0]      quot;
    logic              div_rdy;

    assign divisor = W'(d_q);

    pi_udiv #(.W(W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go_q),
        .dividend (ONE),
        .divisor  (divisor),
        .quot     (quot),
        .rdy      (div_rdy)
    );

    // Odd k subtracts its term, even k adds it.
    always_comb begin
        acc_d = k_q[0] ? (acc_q - quot) : (acc_q + quot);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            d_q     <= '0;
            acc_q   <= '0;
            pi_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            go_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !done_q) begin
                        n_q    <= n_terms;
                        acc_q  <= ONE;
                        k_q    <= KW'(1);
                        d_q    <= KW'(3);
                        busy_q <= 1'b1;
                        if (n_terms != '0) begin
                            state_q <= ST_LOAD;
                            go_q    <= 1'b1;
                        end else begin
                            state_q <= ST_SCALE;
                        end
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= ST_DIV;
                end
                ST_DIV: begin
                    cnt_q <= cnt_q + DIV_CW'(1);
                    if (cnt_q == DIV_CW'(DIV_CYC - 1)) begin
                        state_q <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (div_rdy) begin
                        acc_q <= acc_d;
                    end
                    k_q <= k_q + KW'(1);
                    d_q <= d_q + KW'(2);
                    if (k_q < KW'(n_q)) begin
                        state_q <= ST_LOAD;
                        go_q    <= 1'b1;
                    end else begin
                        state_q <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    pi_q    <= acc_q << 2;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pi_out    = pi_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pi_series_engine.sv
// Self-checking bench for pi_series_engine and its pi_udiv divider: a
// timeline/arithmetic reference model plus directed runs with literal results.
module tb_pi_series_engine;

    import pi_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic [15:0] n_terms = '0;
    logic        busy;
    logic        done;
    logic [31:0] pi_out;
    pi_state_e   state_dbg;

    logic        u_go       = 1'b0;
    logic [31:0] u_dividend = '0;
    logic [31:0] u_divisor  = 32'd1;
    logic [31:0] u_quot;
    logic        u_rdy;

    always #5 clk = ~clk;

    pi_series_engine #(.W(32), .FRAC(16), .N_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_terms   (n_terms),
        .busy      (busy),
        .done      (done),
        .pi_out    (pi_out),
        .state_dbg (state_dbg)
    );

    pi_udiv #(.W(32)) udiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (u_go),
        .dividend (u_dividend),
        .divisor  (u_divisor),
        .quot     (u_quot),
        .rdy      (u_rdy)
    );

    int n_cmp    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_pi(input int n);
        logic [31:0] acc;
        logic [31:0] t;
        acc = 32'(ONE_Q);
        for (int k = 1; k <= n; k++) begin
            t   = 32'(ONE_Q / (2 * k + 1));
            acc = (k % 2 == 1) ? acc - t : acc + t;
        end
        return acc << 2;
    endfunction

    bit          m_run    = 1'b0;
    bit          m_cool   = 1'b0;
    int          m_cnt    = 0;
    int          m_len    = 0;
    logic [31:0] m_res    = '0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic [31:0] exp_pi   = '0;
    logic [31:0] exp_q[$];

    // Timeline model: a run accepted at edge A lasts 34n+2 edges, publishes its
    // result one edge before done, and the done cycle itself ignores start.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run    = 1'b0;
                m_cool   = 1'b0;
                exp_busy = 1'b0;
                exp_done = 1'b0;
                exp_pi   = '0;
                exp_q.delete();
            end else begin
                exp_done = 1'b0;
                if (m_run) begin
                    m_cnt++;
                    if (m_cnt == m_len - 1) exp_pi = m_res;
                    if (m_cnt == m_len) begin
                        exp_done = 1'b1;
                        exp_busy = 1'b0;
                        m_run    = 1'b0;
                        m_cool   = 1'b1;
                    end
                end else if (m_cool) begin
                    m_cool = 1'b0;
                end else if (start) begin
                    m_run    = 1'b1;
                    m_cnt    = 0;
                    m_len    = 34 * int'(n_terms) + 2;
                    m_res    = model_pi(int'(n_terms));
                    exp_busy = 1'b1;
                    exp_q.push_back(m_res);
                end
            end
        end
    end

    // ---------------- per-cycle compare / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (chk_en) begin
                check("busy", 32'(busy), 32'(exp_busy));
                check("done", 32'(done), 32'(exp_done));
                check("pi_out", pi_out, exp_pi);
                check("idle_state", 32'(state_dbg == ST_IDLE), 32'(!m_run));
                if (done === 1'b1) begin
                    check("done_has_result", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("sb_result", pi_out, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_job(input int n, input logic [31:0] exp_val, input int exp_lat);
        int a;
        int lat  = -1;
        bit seen = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        n_terms = n[15:0];
        @(negedge clk);
        start   = 1'b0;
        n_terms = 16'($urandom_range(0, 65535));
        a = cyc;
        for (int i = 0; i < exp_lat + 50 && !seen; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - a;
            end else begin
                @(negedge clk);
            end
        end
        check($sformatf("n%0d_done_seen", n), 32'(seen), 32'd1);
        check($sformatf("n%0d_latency", n), lat, exp_lat);
        check($sformatf("n%0d_pi_out", n), pi_out, exp_val);
        repeat (3) @(negedge clk);
    endtask

    task automatic div_check(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
        int g;
        int lat  = -1;
        bit seen = 1'b0;
        @(negedge clk);
        u_go       = 1'b1;
        u_dividend = a;
        u_divisor  = b;
        @(negedge clk);
        u_go = 1'b0;
        g = cyc;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (u_rdy === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - g;
            end
        end
        check("udiv_rdy_seen", 32'(seen), 32'd1);
        check("udiv_latency", lat, 32);
        check("udiv_quot", u_quot, q);
    endtask

    task automatic spam_run();
        int a;
        int d0;
        int lat  = -1;
        bit seen = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        start   = 1'b1;
        n_terms = 16'd3;
        @(negedge clk);
        a = cyc;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - a;
            end else begin
                n_terms = 16'($urandom_range(0, 65535));
                @(negedge clk);
            end
        end
        // start stays high across the done cycle and must still be ignored there
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("spam_done_seen", 32'(seen), 32'd1);
        check("spam_latency", lat, 104);
        check("spam_done_pulses", done_cnt - d0, 1);
        check("spam_pi_out", pi_out, 32'd189744);
        check("spam_not_restarted", 32'(busy), 32'd0);
    endtask

    task automatic reset_run();
        int d0;
        @(negedge clk);
        start   = 1'b1;
        n_terms = 16'd3;
        @(negedge clk);
        start = 1'b0;
        d0 = done_cnt;
        repeat (49) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_pi_out", pi_out, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        run_job(1, 32'd174764, 36);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pi_out", pi_out, 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_udiv_rdy", 32'(u_rdy), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        check("model_n0", model_pi(0), 32'd262144);
        check("model_n1", model_pi(1), 32'd174764);
        check("model_n2", model_pi(2), 32'd227192);
        check("model_n3", model_pi(3), 32'd189744);

        run_job(0, 32'd262144, 2);
        run_job(1, 32'd174764, 36);
        run_job(2, 32'd227192, 70);
        run_job(3, 32'd189744, 104);
        run_job(2000, model_pi(2000), 68002);

        div_check(32'd65536, 32'd3, 32'd21845);
        div_check(32'd65536, 32'd7, 32'd9362);
        div_check(32'd1000, 32'd33, 32'd30);

        spam_run();
        reset_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: run did not complete by %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
